// File: rtl/sfifo_lvl.sv
// Synchronous FWFT FIFO with occupancy count, almost-full/almost-empty levels,
// flush and full-bypass write. Optional sticky error flags under `SFIFO_LVL_ERR_EN.
module sfifo_lvl #(
  parameter int FW         = 64,
  parameter int DW         = 8,
  parameter int AFULL_LVL  = FW - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DW-1:0]         i_wr_data,
  output logic                  o_full,
  output logic                  o_afull,
  input  logic                  i_rd,
  output logic [DW-1:0]         o_rd_data,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [$clog2(FW):0]   o_count,
  input  logic                  i_clr_err,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int AW = $clog2(FW);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(FW);
  localparam logic [AW:0] AFULL_CNT  = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_CNT = (AW+1)'(AEMPTY_LVL);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr;
  logic [DW-1:0] mem [FW];
  logic          rd_acc;
  logic          wr_acc;

  // The extra wrap bit makes the modulo difference span 0..FW without ambiguity.
  assign o_count  = wr_ptr - rd_ptr;
  assign o_empty  = (o_count == '0);
  assign o_full   = (o_count == FULL_CNT);
  assign o_afull  = (o_count >= AFULL_CNT);
  assign o_aempty = (o_count <= AEMPTY_CNT);

  assign rd_acc = i_rd & ~o_empty;
  // A pop in the same cycle frees the slot, so a write while full still lands.
  assign wr_acc = i_wr_en & (~o_full | rd_acc);

  assign o_rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && wr_acc) mem[wr_ptr[AW-1:0]] <= i_wr_data;
  end

`ifdef SFIFO_LVL_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Set wins over a same-cycle clear; flush freezes the flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!i_flush) begin
      if (i_wr_en && !wr_acc) overflow_q <= 1'b1;
      else if (i_clr_err)     overflow_q <= 1'b0;
      if (i_rd && o_empty)    underflow_q <= 1'b1;
      else if (i_clr_err)     underflow_q <= 1'b0;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = i_clr_err;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule
